// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that fills instruction memory and holds the core in reset until done
module imem_loader #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        core_hold
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_index;
  logic [31:0] r_len;
  logic [23:0] r_shift;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_last_byte;
  logic        w_restart;
  logic [31:0] w_len_full;
  logic [31:0] w_index_next;

  assign w_in_ready   = (r_state == S_LEN) || (r_state == S_DATA);
  assign w_accept     = in_valid && w_in_ready;
  assign w_last_byte  = w_accept && (r_byte_cnt == 2'd3);
  assign w_restart    = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  // Bytes shift in from the top, so the first byte ends up in bits [7:0]
  assign w_len_full   = {in_data, r_len[31:8]};
  assign w_index_next = r_index + 32'd1;

  assign in_ready = w_in_ready;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    we        = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    core_hold = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LEN;
      end
      S_LEN: begin
        busy = 1'b1;
        if (w_last_byte) begin
          if (w_len_full == 32'd0)                   w_next = S_DONE;
          else if (w_len_full > 32'(DEPTH_WORDS))    w_next = S_ERR;
          else                                       w_next = S_DATA;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        if (w_last_byte) w_next = S_WRITE;
      end
      S_WRITE: begin
        busy = 1'b1;
        we   = 1'b1;
        w_next = (w_index_next == r_len) ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
        if (start) w_next = S_LEN;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) w_next = S_LEN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt <= 2'd0;
      r_index    <= 32'd0;
      r_len      <= 32'd0;
      r_shift    <= 24'd0;
      r_waddr    <= 32'd0;
      r_wdata    <= 32'd0;
    end else if (w_restart) begin
      r_byte_cnt <= 2'd0;
      r_index    <= 32'd0;
      r_len      <= 32'd0;
      r_shift    <= 24'd0;
    end else if (r_state == S_LEN) begin
      if (w_accept) begin
        r_len      <= w_len_full;
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
    end else if (r_state == S_DATA) begin
      if (w_accept) begin
        r_shift    <= {in_data, r_shift[23:8]};
        r_byte_cnt <= r_byte_cnt + 2'd1;
        // Address and word are latched together so they stay stable through WRITE and after
        if (r_byte_cnt == 2'd3) begin
          r_wdata <= {in_data, r_shift};
          r_waddr <= BASE_ADDR + {r_index[29:0], 2'b00};
        end
      end
    end else if (r_state == S_WRITE) begin
      r_index    <= w_index_next;
      r_byte_cnt <= 2'd0;
    end
  end

endmodule
